modport_fifo: RTL and testbench
===============================

// Module: modport_fifo
// PURPOSE
//   Single-clock synchronous FIFO with registered read data and status/error flags.
//   Buffers WIDTH-bit words between a producer and a consumer in the same clock domain.
//   Reports full/empty, per-cycle illegal-access pulses and sticky error latches.
// PARAMETERS
//   DEPTH  16  number of entries; power of two, >= 2
//   WIDTH  8   data word width in bits
// PORTS
//   clk           in   1      rising-edge clock
//   rst           in   1      asynchronous, active-low reset
//   write_enable  in   1      write request, sampled at posedge clk
//   read_enable   in   1      read request, sampled at posedge clk
//   data_in       in   WIDTH  write data
//   data_out      out  WIDTH  registered read data
//   full          out  1      count == DEPTH
//   empty         out  1      count == 0
//   overflow      out  1      1-cycle pulse: the write in the previous cycle was rejected (full)
//   underflow     out  1      1-cycle pulse: the read in the previous cycle was rejected (empty)
//   overrun       out  1      sticky: an overflow has occurred since reset
//   underrun      out  1      sticky: an underflow has occurred since reset
// BEHAVIOUR
//   - Reset (rst=0, async): wr_ptr=rd_ptr=0, count=0, data_out=0, empty=1, full=0,
//     overflow=underflow=overrun=underrun=0. The memory array is not cleared.
//   - Pointers are log2(DEPTH) bits and wrap naturally DEPTH-1 -> 0.
//   - count is log2(DEPTH)+1 bits, range 0..DEPTH.
//   - full and empty are decoded combinationally from the registered count.
//   - Write accept: write_enable && (!full || read_enable).
//     On accept: mem[wr_ptr] <= data_in; wr_ptr++.
//   - Read accept: read_enable && !empty.
//     On accept: data_out <= mem[rd_ptr]; rd_ptr++.
//     data_out is valid after the same edge (1-cycle latency) and holds its value when no read is accepted.
//   - Simultaneous read and write, both accepted: count unchanged.
//     When full, the read frees a slot, so the write is accepted.
//   - Empty with read_enable and write_enable: the write is accepted, the read is rejected
//     (underflow). There is no write-through; the word is readable on a later cycle.
//   - Rejected write: memory and pointers unchanged; overflow=1 for exactly the next cycle.
//   - Rejected read: data_out unchanged; underflow=1 for exactly the next cycle.
//   - overrun / underrun set together with the first overflow / underflow pulse.
//     They remain 1 until rst is asserted.
//   - All outputs are registered, or decoded from registered state only. No combinational input->output paths.
// STRUCTURE
//   - Shared package fifo_pkg: DEPTH/WIDTH defaults, localparam PTR_W=$clog2(DEPTH),
//     typedef logic [WIDTH-1:0] data_t.
//   - One sub-module, fifo_mem: DEPTH x WIDTH register array, synchronous write, registered read.
//     Pointers, count and flags live in the top level.
// TESTING
//   1. Reset then idle -> empty=1, full=0, data_out=0, all error flags 0.
//   2. Write 16 words 0x00..0x0F -> full=1 after the 16th edge.
//      Then read 16 -> data_out 0x00..0x0F in order, each 1 cycle after its read; empty=1 at end.
//   3. When full, write 0xAA without a read -> overflow=1 for one cycle, overrun stays 1.
//      Contents intact: the next read returns the oldest word.
//   4. When empty, read -> underflow pulses for one cycle, underrun latches, data_out unchanged.
//   5. When full, read and write 0x55 in the same cycle -> count stays 16, full stays 1, no overflow.
//      0x55 is read back last after the pointers wrap.
//   6. Drive rst low mid-stream at count=7 -> immediate empty=1, data_out=0, sticky flags cleared.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults and types for the synchronous FIFO slice.
// Pointer width and data type follow the default geometry.
package fifo_pkg;

    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned FIFO_WIDTH = 8;
    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);

    typedef logic [FIFO_WIDTH-1:0] data_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, registered read.
// Storage is never reset; only the read register clears.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned WIDTH = FIFO_WIDTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register holds its value whenever no read is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/modport_fifo.sv
// Single-clock FIFO: pointers, occupancy count and error flags around fifo_mem.
// All outputs come from registers or are decoded from the registered count.
module modport_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH,
    parameter int unsigned WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write_enable,
    input  logic             read_enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow,
    output logic             overrun,
    output logic             underrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          wr_acc;
    logic          rd_acc;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

    // A full FIFO is never empty, so a concurrent read always frees the slot.
    always_comb begin
        wr_acc = write_enable && (!full || read_enable);
        rd_acc = read_enable && !empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            overflow  <= write_enable && !wr_acc;
            underflow <= read_enable && !rd_acc;
            overrun   <= overrun  || (write_enable && !wr_acc);
            underrun  <= underrun || (read_enable && !rd_acc);
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

endmodule

// File: tb/tb_modport_fifo.sv
// Randomised scoreboard bench for modport_fifo against a queue-based reference model.
// Stimulus pushes per-cycle expectations; an independent monitor pops and compares.
module tb_modport_fifo;
    import fifo_pkg::*;

    localparam int unsigned DEPTH = 16;

    typedef struct {
        logic [7:0] dout;
        logic       full;
        logic       empty;
        logic       ovf;
        logic       unf;
        logic       ovr;
        logic       unr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       write_enable = 1'b0;
    logic       read_enable  = 1'b0;
    data_t      data_in = '0;
    data_t      data_out;
    logic       full, empty, overflow, underflow, overrun, underrun;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    exp_t       exp_q[$];
    logic [7:0] mq[$];
    logic [7:0] m_dout = '0;
    logic       m_ovr = 1'b0;
    logic       m_unr = 1'b0;

    modport_fifo #(
        .DEPTH (16),
        .WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .overrun      (overrun),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus; the model decides acceptance from occupancy alone.
    task automatic cycle(input logic we, input logic re, input logic [7:0] din);
        exp_t e;
        logic mf, me, wacc, racc;
        @(negedge clk);
        write_enable = we;
        read_enable  = re;
        data_in      = din;
        mf   = (mq.size() == DEPTH);
        me   = (mq.size() == 0);
        wacc = we && (!mf || re);
        racc = re && !me;
        if (racc) m_dout = mq.pop_front();
        if (wacc) mq.push_back(din);
        m_ovr = m_ovr || (we && !wacc);
        m_unr = m_unr || (re && !racc);
        e.dout  = m_dout;
        e.full  = (mq.size() == DEPTH);
        e.empty = (mq.size() == 0);
        e.ovf   = we && !wacc;
        e.unf   = re && !racc;
        e.ovr   = m_ovr;
        e.unr   = m_unr;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_empty"},    32'(empty),     32'd1);
        check({tag, "_full"},     32'(full),      32'd0);
        check({tag, "_data_out"}, 32'(data_out),  32'd0);
        check({tag, "_overflow"}, 32'(overflow),  32'd0);
        check({tag, "_underflow"},32'(underflow), 32'd0);
        check({tag, "_overrun"},  32'(overrun),   32'd0);
        check({tag, "_underrun"}, 32'(underrun),  32'd0);
    endtask

    task automatic async_reset();
        exp_t e;
        @(negedge clk);
        write_enable = 1'b0;
        read_enable  = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_state("async_rst");
        mq.delete();
        m_dout = '0;
        m_ovr  = 1'b0;
        m_unr  = 1'b0;
        e = '{dout: 8'h00, full: 1'b0, empty: 1'b1, ovf: 1'b0, unf: 1'b0, ovr: 1'b0, unr: 1'b0};
        exp_q.push_back(e);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain();
        while (mq.size() > 0) cycle(1'b0, 1'b1, 8'h00);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("data_out",  32'(data_out),  32'(e.dout));
                check("full",      32'(full),      32'(e.full));
                check("empty",     32'(empty),     32'(e.empty));
                check("overflow",  32'(overflow),  32'(e.ovf));
                check("underflow", 32'(underflow), 32'(e.unf));
                check("overrun",   32'(overrun),   32'(e.ovr));
                check("underrun",  32'(underrun),  32'(e.unr));
            end
        end
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        check_reset_state("por");
        rst = 1'b1;

        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i));
        cycle(1'b1, 1'b0, 8'hAA);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        drain();

        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h77);
        drain();

        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i));
        cycle(1'b1, 1'b1, 8'h55);
        cycle(1'b0, 1'b0, 8'h00);
        drain();
        cycle(1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 30, 8'($urandom));
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 80, 8'($urandom));
        for (int i = 0; i < 200; i++)
            cycle($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50, 8'($urandom));

        drain();
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'($urandom));
        async_reset();

        for (int i = 0; i < 100; i++)
            cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50, 8'($urandom));
        cycle(1'b0, 1'b0, 8'h00);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_left", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
